shift_add_multiplier: RTL and testbench

//   Sequential shift-and-add multiply-accumulate, the inverse of the integer divider:

---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier_if.sv | 26 ++
 rtl/shift_add_multiplier_dp.sv | 67 ++++++
 rtl/shift_add_multiplier.sv | 88 ++++++++
 tb/tb_shift_add_multiplier.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate block:
// FSM state encoding, state-output width and counter sizing helper.
package shift_add_multiplier_pkg;

   localparam int CS_W = 2;

   typedef enum logic [CS_W-1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bits needed for a down-counter that starts at width and stops at 1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for the shift-and-add multiplier.
// master drives the request side, slave is the multiplier itself.
interface shift_add_multiplier_if
   import shift_add_multiplier_pkg::*;
   #(parameter int WIDTH = 4);

   logic                 go;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     addend;
   logic [2*WIDTH-1:0]   product;
   logic                 done;
   logic                 busy;
   logic [CS_W-1:0]      cs;

   modport master (
      output go, multiplicand, multiplier, addend,
      input  product, done, busy, cs
   );

   modport slave (
      input  go, multiplicand, multiplier, addend,
      output product, done, busy, cs
   );

endinterface

// File: rtl/shift_add_multiplier_dp.sv
// Datapath for the shift-and-add multiplier: multiplicand shift register A,
// multiplier shift register B, accumulator P, step down-counter and the
// registered product. All sequencing decisions come from the FSM in the top.
module mult_dp
   import shift_add_multiplier_pkg::*;
   #(parameter int WIDTH = 4)
   (
      input  logic               clk,
      input  logic               rst,
      input  logic               ld,
      input  logic               step,
      input  logic               add_en,
      input  logic               ld_prod,
      input  logic [WIDTH-1:0]   multiplicand,
      input  logic [WIDTH-1:0]   multiplier,
      input  logic [WIDTH-1:0]   addend,
      output logic [2*WIDTH-1:0] product,
      output logic               cnt_last,
      output logic               b0
   );

   localparam int CW = cnt_width(WIDTH);

   logic [2*WIDTH-1:0] a_reg;
   logic [2*WIDTH-1:0] p_reg;
   logic [2*WIDTH-1:0] p_next;
   logic [WIDTH-1:0]   b_reg;
   logic [CW-1:0]      cnt;

   // Accumulator value after this step; also what gets latched into product on the last step.
   always_comb begin
      p_next = add_en ? (p_reg + a_reg) : p_reg;
   end

   // Capture operands on ld, then shift/accumulate one multiplier bit per step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg <= '0;
         b_reg <= '0;
         p_reg <= '0;
         cnt   <= '0;
      end else if (ld) begin
         a_reg <= {{WIDTH{1'b0}}, multiplicand};
         b_reg <= multiplier;
         p_reg <= {{WIDTH{1'b0}}, addend};
         cnt   <= CW'(WIDTH);
      end else if (step) begin
         p_reg <= p_next;
         a_reg <= a_reg << 1;
         b_reg <= b_reg >> 1;
         cnt   <= cnt - CW'(1);
      end
   end

   // Product only moves on the final step, so it holds steady through DONE and IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         product <= '0;
      end else if (ld_prod) begin
         product <= p_next;
      end
   end

   assign cnt_last = (cnt == CW'(1));
   assign b0       = b_reg[0];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential multiply-accumulate: product = multiplicand*multiplier + addend.
// Fixed latency of WIDTH RUN cycles followed by a single DONE cycle, with the
// same go/done/cs handshake as the companion divider so the two can be chained.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
   #(parameter int WIDTH = 4)
   (
      input  logic                     clk,
      input  logic                     rst,
      shift_add_multiplier_if.slave    bus
   );

   state_t state;
   state_t next_state;

   logic ld;
   logic step;
   logic add_en;
   logic ld_prod;
   logic cnt_last;
   logic b0;

   // State register; reset drops straight to IDLE, aborting any operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:  next_state = bus.go ? S_RUN : S_IDLE;
         S_RUN:   next_state = cnt_last ? S_DONE : S_RUN;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath controls and Moore status outputs decoded from the current state.
   always_comb begin
      ld       = 1'b0;
      step     = 1'b0;
      add_en   = 1'b0;
      ld_prod  = 1'b0;
      bus.done = 1'b0;
      bus.busy = 1'b0;
      case (state)
         S_IDLE: begin
            ld = bus.go;
         end
         S_RUN: begin
            step     = 1'b1;
            add_en   = b0;
            ld_prod  = cnt_last;
            bus.busy = 1'b1;
         end
         S_DONE: begin
            bus.done = 1'b1;
            bus.busy = 1'b1;
         end
         default: begin
            ld = 1'b0;
         end
      endcase
   end

   assign bus.cs = state;

   mult_dp #(.WIDTH(WIDTH)) u_dp (
      .clk          (clk),
      .rst          (rst),
      .ld           (ld),
      .step         (step),
      .add_en       (add_en),
      .ld_prod      (ld_prod),
      .multiplicand (bus.multiplicand),
      .multiplier   (bus.multiplier),
      .addend       (bus.addend),
      .product      (bus.product),
      .cnt_last     (cnt_last),
      .b0           (b0)
   );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4): stimulus pushes the
// arithmetic expectation a*b+c into a scoreboard, a monitor pops it on every done.
module tb_shift_add_multiplier;

   localparam int WIDTH  = 4;
   localparam int PERIOD = 10;

   logic clk;
   logic rst;

   int assertCount = 0;
   int failCount   = 0;
   int cycleCnt    = 0;
   bit prevDone    = 1'b0;

   logic [2*WIDTH-1:0] sb[$];
   int                 doneCycles[$];

   shift_add_multiplier_if #(.WIDTH(WIDTH)) dut_if ();

   shift_add_multiplier #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #(PERIOD/2) clk = ~clk;
   end

   // Cycle counter used to measure spacing between done pulses
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
   end

   // One comparison: counts it, reports a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: on each done pulse pop the oldest expectation and compare
   always @(negedge clk) begin
      if (rst === 1'b1 && dut_if.done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'(dut_if.done), 32'd0);
         end else begin
            checkOutput("product", 32'(dut_if.product), 32'(sb.pop_front()));
            checkOutput("busy_in_done", 32'(dut_if.busy), 32'd1);
            checkOutput("cs_in_done", 32'(dut_if.cs), 32'd2);
         end
         if (prevDone) checkOutput("done_pulse_width", 32'd2, 32'd1);
         doneCycles.push_back(cycleCnt);
      end
      prevDone = (rst === 1'b1) && (dut_if.done === 1'b1);
   end

   // Bounded wait for the multiplier to return to IDLE
   task automatic waitIdle();
      int n = 0;
      while (dut_if.busy !== 1'b0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) checkOutput("idle_timeout", 32'(dut_if.busy), 32'd0);
   endtask

   // Issue one operation with a single-cycle go pulse; returns just after the capture edge
   task automatic applyStimulus(input int mc, input int mp, input int ad);
      waitIdle();
      dut_if.multiplicand = WIDTH'(mc);
      dut_if.multiplier   = WIDTH'(mp);
      dut_if.addend       = WIDTH'(ad);
      dut_if.go           = 1'b1;
      sb.push_back((2*WIDTH)'(mc * mp + ad));
      @(posedge clk); #1;
      dut_if.go = 1'b0;
   endtask

   // Bounded wait until every expectation has been consumed
   task automatic drainScoreboard();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   // Global watchdog
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int q, r;
      dut_if.go           = 1'b0;
      dut_if.multiplicand = '0;
      dut_if.multiplier   = '0;
      dut_if.addend       = '0;
      rst = 1'b0;

      // Reset then idle with go low: everything stays at reset values
      #(PERIOD*2 + 3);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle_product", 32'(dut_if.product), 32'd0);
         checkOutput("idle_done", 32'(dut_if.done), 32'd0);
         checkOutput("idle_busy", 32'(dut_if.busy), 32'd0);
         checkOutput("idle_cs", 32'(dut_if.cs), 32'd0);
      end

      // Basic op with latency measurement and post-completion hold
      @(posedge clk); #1;
      applyStimulus(5, 3, 0);
      n = 0;
      while (dut_if.done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("latency_edges", 32'(n), 32'(WIDTH));
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("product_hold", 32'(dut_if.product), 32'd15);
      checkOutput("cs_back_idle", 32'(dut_if.cs), 32'd0);

      // Boundary operands
      applyStimulus(15, 15, 15);
      applyStimulus(0, 9, 7);
      applyStimulus(0, 0, 0);
      applyStimulus(15, 0, 15);
      drainScoreboard();

      // go held high: back-to-back ops, operands changed while running
      waitIdle();
      doneCycles.delete();
      dut_if.multiplicand = 4'd3;
      dut_if.multiplier   = 4'd4;
      dut_if.addend       = 4'd1;
      dut_if.go           = 1'b1;
      sb.push_back(8'd13);
      @(posedge clk); #1;
      dut_if.multiplicand = 4'd6;
      dut_if.multiplier   = 4'd2;
      dut_if.addend       = 4'd5;
      sb.push_back(8'd17);
      repeat (WIDTH + 2) begin
         @(posedge clk); #1;
      end
      dut_if.go = 1'b0;
      n = 0;
      while (doneCycles.size() < 2 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("b2b_done_count", 32'(doneCycles.size()), 32'd2);
      if (doneCycles.size() >= 2)
         checkOutput("b2b_done_spacing", 32'(doneCycles[1] - doneCycles[0]), 32'(WIDTH + 2));
      drainScoreboard();

      // Asynchronous reset in the second RUN cycle aborts the op
      applyStimulus(9, 9, 3);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      sb.delete();
      checkOutput("abort_product", 32'(dut_if.product), 32'd0);
      checkOutput("abort_done", 32'(dut_if.done), 32'd0);
      checkOutput("abort_busy", 32'(dut_if.busy), 32'd0);
      checkOutput("abort_cs", 32'(dut_if.cs), 32'd0);
      @(posedge clk); #3;
      rst = 1'b1;
      for (int i = 0; i < WIDTH + 3; i++) begin
         @(negedge clk);
         checkOutput("post_abort_no_done", 32'(dut_if.done), 32'd0);
      end
      applyStimulus(7, 7, 2);
      drainScoreboard();

      // Divider chaining: quotient*divisor + remainder rebuilds the dividend
      for (int dvd = 0; dvd < 16; dvd++) begin
         for (int dvs = 1; dvs < 16; dvs++) begin
            q = dvd / dvs;
            r = dvd % dvs;
            applyStimulus(dvs, q, r);
         end
      end
      drainScoreboard();

      // Random operands
      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      drainScoreboard();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
